crc_ch_buf_seq: RTL and testbench

//   Sequencer for the 128-word channel data buffer, sitting directly upstream of the
//   MB data-path slices. Arbitrates the single-port buffer between two sides:
//     - MB-side writes (memory words arriving through the MB mixers);
//     - CBUS-side reads (words delivered to the channel bus).

---
 rtl/crc_ch_buf_seq.sv | 124 ++++++++++++
 tb/tb_crc_ch_buf_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/crc_ch_buf_seq.sv
// Channel data buffer sequencer: arbitrates MB writes against CBUS reads
// on the single-port buffer and keeps the circular pointers and count.
module crc_ch_buf_seq #(
    parameter int ADR_W       = 7,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk_crc_h,
    input  logic             crc_reset_h,
    input  logic             mb_wr_req_h,
    input  logic             cbus_rd_req_h,
    input  logic             ch_reverse_h,
    input  logic             buf_clr_h,
    output logic [ADR_W-1:0] crc_ch_buf_adr_h,
    output logic             ch_buf_wr_l,
    output logic             crc_buf_mb_sel_h,
    output logic             crc_cbus_out_hold_h,
    output logic             mb_wr_ack_h,
    output logic             cbus_rd_ack_h,
    output logic [ADR_W:0]   buf_count_h,
    output logic             buf_empty_h,
    output logic             buf_full_h,
    output logic             ch_buf_ovf_h
);

    typedef enum logic [1:0] {IDLE, MB_WR, CB_RD, CB_HOLD} state_t;

    localparam logic [ADR_W:0] DEPTH     = {1'b1, {ADR_W{1'b0}}};
    localparam logic [1:0]     HOLD_LAST = 2'(HOLD_CYCLES - 1);

    state_t           state_q;
    logic [ADR_W-1:0] wr_ptr_q, rd_ptr_q, adr_q;
    logic [ADR_W-1:0] wr_ptr_d, rd_ptr_d;
    logic [ADR_W:0]   cnt_q;
    logic [1:0]       hold_cnt_q;
    logic             dir_q, ovf_q, last_wr_q;

    logic full, empty, wr_elig, rd_elig, grant_wr, grant_rd, hold_last;

    assign full      = (cnt_q == DEPTH);
    assign empty     = (cnt_q == '0);
    assign wr_elig   = mb_wr_req_h & ~full;
    assign rd_elig   = cbus_rd_req_h & ~empty;
    // Round robin: on contention the side not served last wins.
    assign grant_wr  = wr_elig & (~rd_elig | ~last_wr_q);
    assign grant_rd  = rd_elig & ~grant_wr;
    assign hold_last = (hold_cnt_q == HOLD_LAST);

    assign wr_ptr_d = dir_q ? wr_ptr_q - 1'b1 : wr_ptr_q + 1'b1;
    assign rd_ptr_d = dir_q ? rd_ptr_q - 1'b1 : rd_ptr_q + 1'b1;

    always_ff @(posedge clk_crc_h) begin
        if (crc_reset_h) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            adr_q      <= '0;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            dir_q      <= 1'b0;
            ovf_q      <= 1'b0;
            last_wr_q  <= 1'b0;
        end else if (buf_clr_h) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            adr_q      <= '0;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            dir_q      <= ch_reverse_h;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (empty)
                        dir_q <= ch_reverse_h;
                    if (mb_wr_req_h && full)
                        ovf_q <= 1'b1;
                    if (grant_wr) begin
                        state_q   <= MB_WR;
                        adr_q     <= wr_ptr_q;
                        last_wr_q <= 1'b1;
                    end else if (grant_rd) begin
                        state_q   <= CB_RD;
                        adr_q     <= rd_ptr_q;
                        last_wr_q <= 1'b0;
                    end
                end
                MB_WR: begin
                    wr_ptr_q <= wr_ptr_d;
                    cnt_q    <= cnt_q + 1'b1;
                    state_q  <= IDLE;
                end
                CB_RD: begin
                    hold_cnt_q <= '0;
                    state_q    <= CB_HOLD;
                end
                CB_HOLD: begin
                    if (hold_last) begin
                        rd_ptr_q <= rd_ptr_d;
                        cnt_q    <= cnt_q - 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign crc_ch_buf_adr_h    = adr_q;
    assign ch_buf_wr_l         = (state_q != MB_WR);
    assign crc_buf_mb_sel_h    = (state_q == MB_WR);
    assign crc_cbus_out_hold_h = (state_q == CB_HOLD);
    // An aborting clear or reset suppresses the ack of the cycle it lands in.
    assign mb_wr_ack_h   = (state_q == MB_WR) & ~buf_clr_h & ~crc_reset_h;
    assign cbus_rd_ack_h = (state_q == CB_HOLD) & hold_last
                           & ~buf_clr_h & ~crc_reset_h;
    assign buf_count_h   = cnt_q;
    assign buf_empty_h   = empty;
    assign buf_full_h    = full;
    assign ch_buf_ovf_h  = ovf_q;

endmodule

// File: tb/tb_crc_ch_buf_seq.sv
// Directed bench for crc_ch_buf_seq with HOLD_CYCLES=2.
module tb_crc_ch_buf_seq;

    logic       clk = 1'b0;
    logic       rst, wr_req, rd_req, rev, clr;
    logic [6:0] adr;
    logic [7:0] cnt;
    logic       wr_l, sel, hold, wack, rack, empty, full, ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    crc_ch_buf_seq #(.ADR_W(7), .HOLD_CYCLES(2)) dut (
        .clk_crc_h          (clk),
        .crc_reset_h        (rst),
        .mb_wr_req_h        (wr_req),
        .cbus_rd_req_h      (rd_req),
        .ch_reverse_h       (rev),
        .buf_clr_h          (clr),
        .crc_ch_buf_adr_h   (adr),
        .ch_buf_wr_l        (wr_l),
        .crc_buf_mb_sel_h   (sel),
        .crc_cbus_out_hold_h(hold),
        .mb_wr_ack_h        (wack),
        .cbus_rd_ack_h      (rack),
        .buf_count_h        (cnt),
        .buf_empty_h        (empty),
        .buf_full_h         (full),
        .ch_buf_ovf_h       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One write with request already held; ends on the following IDLE cycle.
    task automatic do_write(input int exp_adr, input int exp_cnt);
        @(negedge clk);
        chk("wr_strobe", 32'(wr_l), 0);
        chk("wr_sel", 32'(sel), 1);
        chk("wr_ack", 32'(wack), 1);
        chk("wr_adr", 32'(adr), exp_adr);
        @(negedge clk);
        chk("wr_idle_strobe", 32'(wr_l), 1);
        chk("wr_count", 32'(cnt), exp_cnt);
    endtask

    task automatic do_read(input int exp_adr, input int exp_cnt);
        @(negedge clk);
        chk("rd_strobe", 32'(wr_l), 1);
        chk("rd_ram_hold", 32'(hold), 0);
        chk("rd_adr", 32'(adr), exp_adr);
        @(negedge clk);
        chk("rd_hold1", 32'(hold), 1);
        chk("rd_ack_early", 32'(rack), 0);
        @(negedge clk);
        chk("rd_hold2", 32'(hold), 1);
        chk("rd_ack", 32'(rack), 1);
        chk("rd_hold_adr", 32'(adr), exp_adr);
        @(negedge clk);
        chk("rd_idle_hold", 32'(hold), 0);
        chk("rd_count", 32'(cnt), exp_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; rev = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_adr", 32'(adr), 0);
        chk("rst_wr_l", 32'(wr_l), 1);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_wack", 32'(wack), 0);
        chk("rst_rack", 32'(rack), 0);
        chk("rst_hold", 32'(hold), 0);
        chk("rst_sel", 32'(sel), 0);
        rst = 1'b0;

        // Fill forward, then one request against a full buffer
        wr_req = 1'b1;
        for (int i = 0; i < 128; i++) do_write(i, i + 1);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(cnt), 128);
        @(negedge clk);
        chk("ovf_no_strobe", 32'(wr_l), 1);
        chk("ovf_no_ack", 32'(wack), 0);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_count", 32'(cnt), 128);
        wr_req = 1'b0;

        // Drain
        rd_req = 1'b1;
        for (int i = 0; i < 128; i++) do_read(i, 127 - i);
        rd_req = 1'b0;
        chk("drain_empty", 32'(empty), 1);
        chk("drain_full", 32'(full), 0);

        // Reverse order from empty
        rev = 1'b1;
        wr_req = 1'b1;
        do_write(0, 1);
        do_write(127, 2);
        do_write(126, 3);
        wr_req = 1'b0;
        rd_req = 1'b1;
        do_read(0, 2);
        do_read(127, 1);
        do_read(126, 0);
        rd_req = 1'b0;
        rev = 1'b0;

        // Clear flushes pointers and the sticky overflow
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_count", 32'(cnt), 0);
        chk("clr_empty", 32'(empty), 1);

        // Contention: last grant a read, so MB goes first
        wr_req = 1'b1;
        for (int i = 0; i < 5; i++) do_write(i, i + 1);
        wr_req = 1'b0;
        rd_req = 1'b1;
        do_read(0, 4);
        wr_req = 1'b1;
        do_write(5, 5);
        do_read(1, 4);
        do_write(6, 5);
        do_read(2, 4);
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Clear during the first hold cycle
        rd_req = 1'b1;
        @(negedge clk);
        chk("abort_rd_adr", 32'(adr), 3);
        chk("abort_rd_hold", 32'(hold), 0);
        @(negedge clk);
        chk("abort_hold1", 32'(hold), 1);
        chk("abort_ack1", 32'(rack), 0);
        clr = 1'b1;
        rd_req = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_hold_off", 32'(hold), 0);
        chk("abort_no_ack", 32'(rack), 0);
        chk("abort_count", 32'(cnt), 0);
        chk("abort_empty", 32'(empty), 1);
        @(negedge clk);
        chk("abort_idle_ack", 32'(rack), 0);
        wr_req = 1'b1;
        do_write(0, 1);
        wr_req = 1'b0;
        rd_req = 1'b1;
        do_read(0, 0);
        rd_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
